// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_frame_ctrl                                                             |
// | Frames a sample stream into an N-point streaming FFT and hands its results |
// | downstream with bin markers, back-pressure, flush/drain and restart.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fft_frame_ctrl #(
    parameter int IWIDTH  = 15,
    parameter int OWIDTH  = 21,
    parameter int LGWIDTH = 11
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2*IWIDTH-1:0]   i_sample,
    input  logic                  i_flush,
    output logic                  o_fft_reset,
    output logic                  o_fft_ce,
    output logic [2*IWIDTH-1:0]   o_fft_sample,
    input  logic [2*OWIDTH-1:0]   i_fft_result,
    input  logic                  i_fft_sync,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [2*OWIDTH-1:0]   o_result,
    output logic                  o_first,
    output logic                  o_last,
    output logic                  o_done,
    output logic                  o_sync_err
);

    localparam logic [LGWIDTH-1:0] c_last_bin = {LGWIDTH{1'b1}};
    localparam logic [LGWIDTH-1:0] c_one      = LGWIDTH'(1);

    typedef enum logic [1:0] {
        S_CLR   = 2'd0,
        S_RUN   = 2'd1,
        S_PAD   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LGWIDTH-1:0] in_cnt_q, in_cnt_d;
    logic [LGWIDTH-1:0] out_cnt_q, out_cnt_d;
    logic [3:0]         pending_q, pending_d;
    logic               started_q, started_d;
    logic               avail_q, avail_d;
    logic               sync_err_q, sync_err_d;

    logic w_out_ok, w_out_hs, w_counting, w_frame_done, w_last_hs;

    // avail_q: the FFT output has moved since the last ce and is not yet consumed
    always_comb begin
        o_fft_reset  = (state_q == S_CLR);
        o_valid      = avail_q && (started_q || i_fft_sync) && (pending_q != 4'd0)
                       && (state_q != S_CLR);
        w_out_ok     = !o_valid || i_ready;
        o_ready      = 1'b0;
        o_fft_ce     = 1'b0;
        o_fft_sample = '0;
        case (state_q)
            S_RUN: begin
                o_ready      = w_out_ok;
                o_fft_ce     = i_valid && w_out_ok;
                o_fft_sample = i_sample;
            end
            S_PAD, S_FLUSH: o_fft_ce = w_out_ok;
            default: ;
        endcase

        w_out_hs     = o_valid && i_ready;
        w_counting   = o_fft_ce && ((state_q == S_RUN) || (state_q == S_PAD));
        w_frame_done = w_counting && (in_cnt_q == c_last_bin);
        w_last_hs    = w_out_hs && (out_cnt_q == c_last_bin);

        in_cnt_d   = w_counting ? in_cnt_q + c_one : in_cnt_q;
        out_cnt_d  = w_out_hs ? out_cnt_q + c_one : out_cnt_q;
        pending_d  = pending_q;
        if (w_frame_done && !w_last_hs)
            pending_d = pending_q + 4'd1;
        else if (!w_frame_done && w_last_hs)
            pending_d = pending_q - 4'd1;
        started_d  = started_q || (avail_q && i_fft_sync);
        avail_d    = o_fft_ce ? 1'b1 : (w_out_hs ? 1'b0 : avail_q);
        sync_err_d = sync_err_q || (o_valid && i_fft_sync && (out_cnt_q != '0));

        o_done  = 1'b0;
        state_d = state_q;
        case (state_q)
            S_CLR: begin
                state_d   = S_RUN;
                in_cnt_d  = '0;
                out_cnt_d = '0;
                pending_d = '0;
                started_d = 1'b0;
                avail_d   = 1'b0;
            end
            S_RUN: begin
                // in_cnt_d already includes this cycle's accepted sample
                if (i_flush)
                    state_d = (in_cnt_d != '0) ? S_PAD : S_FLUSH;
            end
            S_PAD: begin
                if (w_frame_done)
                    state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (pending_d == 4'd0) begin
                    o_done  = 1'b1;
                    state_d = S_CLR;
                end
            end
            default: state_d = S_CLR;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_CLR;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            pending_q  <= '0;
            started_q  <= 1'b0;
            avail_q    <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            pending_q  <= pending_d;
            started_q  <= started_d;
            avail_q    <= avail_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign o_result   = i_fft_result;
    assign o_first    = (out_cnt_q == '0);
    assign o_last     = (out_cnt_q == c_last_bin);
    assign o_sync_err = sync_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fft_frame_ctrl                                                          |
// | Random-stimulus scoreboard bench for fft_frame_ctrl with a delay-line FFT. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fft_frame_ctrl;

    localparam int IW = 15;
    localparam int OW = 21;
    localparam int LG = 11;
    localparam int N  = 1 << LG;
    localparam int D  = N + 7;
    localparam int SW = 2 * IW;

    logic          clk;
    logic          i_reset_n, i_valid, o_ready, i_flush;
    logic [SW-1:0] i_sample, o_fft_sample;
    logic          o_fft_reset, o_fft_ce;
    logic [2*OW-1:0] i_fft_result, o_result;
    logic          i_fft_sync, o_valid, i_ready, o_first, o_last, o_done, o_sync_err;

    fft_frame_ctrl #(.IWIDTH(IW), .OWIDTH(OW), .LGWIDTH(LG)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_sample(i_sample), .i_flush(i_flush), .o_fft_reset(o_fft_reset),
        .o_fft_ce(o_fft_ce), .o_fft_sample(o_fft_sample), .i_fft_result(i_fft_result),
        .i_fft_sync(i_fft_sync), .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_first(o_first), .o_last(o_last), .o_done(o_done),
        .o_sync_err(o_sync_err)
    );

    typedef struct {
        logic [2*OW-1:0] res;
        logic            first;
        logic            last;
    } exp_t;

    exp_t          exp_q[$];
    logic [SW-1:0] cur[$];
    logic [SW-1:0] hist[$];
    int n_checks = 0, n_err = 0;
    int n_out = 0, n_valid_cyc = 0, done_cnt = 0;
    int rmode = 0;
    logic inject_sync = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2*OW-1:0] fft_map(input logic [SW-1:0] s);
        return {{(OW-IW){1'b0}}, s[SW-1:IW], {(OW-IW){1'b0}}, s[IW-1:0]};
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic void fail(input string name, input string what);
        n_checks++;
        n_err++;
        $display("FAIL %s: %s", name, what);
    endfunction

    // Reference model: accepted samples grouped into N-point frames
    function automatic void push_frame();
        exp_t e;
        for (int b = 0; b < N; b++) begin
            e.res   = fft_map(cur[b]);
            e.first = (b == 0);
            e.last  = (b == N - 1);
            exp_q.push_back(e);
        end
        cur.delete();
    endfunction

    function automatic void model_accept(input logic [SW-1:0] s);
        cur.push_back(s);
        if (cur.size() == N) push_frame();
    endfunction

    function automatic void model_flush();
        if (cur.size() != 0) begin
            while (cur.size() < N) cur.push_back('0);
            push_frame();
        end
    endfunction

    // Streaming FFT stand-in: output tracks the input D clock-enables ago
    initial begin
        logic          s_ce, s_rst;
        logic [SW-1:0] s_smp;
        int            j;
        i_fft_result = '0;
        i_fft_sync   = 1'b0;
        forever begin
            @(negedge clk);
            s_ce  = o_fft_ce;
            s_rst = o_fft_reset;
            s_smp = o_fft_sample;
            @(posedge clk);
            #1;
            if (s_rst) begin
                hist.delete();
                i_fft_result = '0;
                i_fft_sync   = 1'b0;
            end else if (s_ce) begin
                hist.push_back(s_smp);
                j = hist.size() - D;
                if (j >= 0) begin
                    i_fft_result = fft_map(hist[j]);
                    i_fft_sync   = ((j % N) == 0) || (inject_sync && ((j % N) == 5));
                end
            end
        end
    end

    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       i_ready = 1'b1;
                1:       i_ready = ~i_ready;
                default: i_ready = (int'($urandom_range(99)) < 75);
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_done) chk("reset_after_done", 64'(o_fft_reset), 64'(1));
            prev_done = o_done;
            if (o_done) done_cnt++;
            if (o_valid) begin
                n_valid_cyc++;
                if (!i_ready) chk("ce_while_stalled", 64'(o_fft_ce), 64'(0));
            end
            if (o_valid && i_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    fail("extra_output", "actual=valid result required=no result");
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 64'(o_result), 64'(e.res));
                    chk("first",  64'(o_first),  64'(e.first));
                    chk("last",   64'(o_last),   64'(e.last));
                end
            end
        end
    end

    task automatic send_samples(input int n, input int vpct, input int stop_after);
        int base, guard;
        logic [SW-1:0] s;
        base = n_out;
        for (int k = 0; k < n; k++) begin
            if (stop_after >= 0 && (n_out - base) >= stop_after) break;
            while (int'($urandom_range(99)) >= vpct) begin
                i_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            s = SW'($urandom);
            i_valid  = 1'b1;
            i_sample = s;
            guard = 0;
            forever begin
                @(negedge clk);
                if (o_ready) break;
                guard++;
                if (guard > 2000) begin
                    fail("accept_timeout", "actual=no o_ready required=accept within 2000 cycles");
                    i_valid = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
            end
            model_accept(s);
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
    endtask

    task automatic do_flush(input int hold, input int max_lat);
        int base_done, vbase, cyc;
        base_done = done_cnt;
        vbase     = n_valid_cyc;
        i_valid   = 1'b0;
        i_flush   = 1'b1;
        model_flush();
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        i_flush = 1'b0;
        cyc = hold;
        while (done_cnt == base_done && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("flush_done_seen", 64'(done_cnt != base_done), 64'(1));
        if (max_lat > 0) begin
            chk("flush_done_latency", 64'(cyc <= max_lat), 64'(1));
            chk("flush_no_valid", 64'(n_valid_cyc - vbase), 64'(0));
        end
        chk("results_drained", 64'(exp_q.size()), 64'(0));
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("done_once", 64'(done_cnt - base_done), 64'(1));
    endtask

    task automatic check_reset_state();
        chk("rst_fft_reset", 64'(o_fft_reset), 64'(1));
        chk("rst_fft_ce",    64'(o_fft_ce),    64'(0));
        chk("rst_ready",     64'(o_ready),     64'(0));
        chk("rst_valid",     64'(o_valid),     64'(0));
        chk("rst_done",      64'(o_done),      64'(0));
        chk("rst_sync_err",  64'(o_sync_err),  64'(0));
        chk("rst_first",     64'(o_first),     64'(1));
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        i_reset_n = 1'b1;
        @(negedge clk);
        chk("clr_cycle_fft_reset", 64'(o_fft_reset), 64'(1));
        chk("clr_cycle_ready",     64'(o_ready),     64'(0));
        @(negedge clk);
        chk("run_fft_reset_low",   64'(o_fft_reset), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_sample  = '0;
        i_flush   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        release_reset();

        // Back-to-back frames, downstream always ready
        rmode = 0;
        send_samples(4 * N, 90, -1);
        do_flush(1, 0);
        chk("no_sync_err_clean", 64'(o_sync_err), 64'(0));

        // Downstream ready toggling every cycle
        rmode = 1;
        send_samples(2 * N, 100, -1);
        do_flush(1, 0);

        // Flush 100 samples into the second frame, flush held into PAD
        rmode = 2;
        send_samples(N + 100, 85, -1);
        do_flush(2, 0);

        // Flush with nothing in flight
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        do_flush(2, 2);

        // Stray sync at bin 5
        rmode = 0;
        chk("sync_err_before", 64'(o_sync_err), 64'(0));
        inject_sync = 1'b1;
        send_samples(N, 95, -1);
        do_flush(1, 0);
        inject_sync = 1'b0;
        chk("sync_err_set", 64'(o_sync_err), 64'(1));
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        chk("sync_err_sticky", 64'(o_sync_err), 64'(1));

        // Reset in the middle of an output frame
        rmode = 2;
        send_samples(3 * N, 95, 1000);
        i_valid   = 1'b0;
        i_reset_n = 1'b0;
        #1;
        chk("midframe_valid_drop", 64'(o_valid), 64'(0));
        exp_q.delete();
        cur.delete();
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        release_reset();
        send_samples(N, 90, -1);
        do_flush(1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: actual=still running required=finished before 95000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
